bit_serial_adder: RTL and testbench

//  Parametrised, multi-cycle successor to the 1-bit full-adder cell. It adds or

---
 rtl/bit_serial_adder.sv | 128 ++++++++++++
 tb/tb_bit_serial_adder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial add/subtract of two WIDTH-bit operands through one registered full-adder slice, LSB first.
// Latency: Done pulses WIDTH cycles after the accepting Start edge; Sum and flags are then held.
// Backpressure: none; Start is ignored while Busy and accepted again in the Done cycle.
module bit_serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        s_bit    = a_q[0] ^ b_q[0] ^ c_q;
        c_next   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        acc_next = {s_bit, acc_q[WIDTH-1:1]};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    // Subtraction is A + ~B + 1, so B is inverted and carry forced here.
                    state_d = S_RUN;
                    a_d     = A;
                    b_d     = B ^ {WIDTH{Mode}};
                    c_d     = Mode ? 1'b1 : Cin;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_next;
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // c_q is the carry into the MSB at this point.
                    state_d = S_DONE;
                    cnt_d   = cnt_q;
                    sum_d   = acc_next;
                    carry_d = c_next;
                    ovf_d   = c_q ^ c_next;
                    zero_d  = (acc_next == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign Busy     = (state_q == S_RUN);
    assign Done     = (state_q == S_DONE);
    assign Sum      = sum_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at WIDTH=4 and WIDTH=8 with hand-computed vectors.
module tb_bit_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
        logic       zero;
        int         cyc;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    int         cyc = 0;
    int         total = 0;
    int         passed = 0;
    exp_t       q4[$];
    exp_t       q8[$];

    logic       start4 = 1'b0, mode4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, carry4, ovf4, zero4;
    logic [3:0] sum4;

    logic       start8 = 1'b0, mode8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, carry8, ovf8, zero8;
    logic [7:0] sum8;

    bit_serial_adder #(.WIDTH(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .Start(start4), .Mode(mode4), .A(a4), .B(b4), .Cin(cin4),
        .Busy(busy4), .Done(done4), .Sum(sum4), .Carry(carry4), .Overflow(ovf4), .Zero(zero4)
    );

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Rst(Rst), .Start(start8), .Mode(mode8), .A(a8), .B(b8), .Cin(cin8),
        .Busy(busy8), .Done(done8), .Sum(sum8), .Carry(carry8), .Overflow(ovf8), .Zero(zero8)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge Clk) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                total++;
                $display("FAIL done4_unexpected: Done high with no pending result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("sum4",   {24'd0, 4'd0, sum4}, {24'd0, e.sum});
                chk("carry4", {31'd0, carry4}, {31'd0, e.carry});
                chk("ovf4",   {31'd0, ovf4},   {31'd0, e.ovf});
                chk("zero4",  {31'd0, zero4},  {31'd0, e.zero});
                chk("lat4",   cyc, e.cyc);
            end
        end
    end

    always @(negedge Clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                total++;
                $display("FAIL done8_unexpected: Done high with no pending result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("sum8",   {24'd0, sum8},   {24'd0, e.sum});
                chk("carry8", {31'd0, carry8}, {31'd0, e.carry});
                chk("ovf8",   {31'd0, ovf8},   {31'd0, e.ovf});
                chk("zero8",  {31'd0, zero8},  {31'd0, e.zero});
                chk("lat8",   cyc, e.cyc);
            end
        end
    end

    // Drives a request now; it is taken at the next rising edge.
    task automatic issue4(input logic m, input logic [3:0] a, input logic [3:0] b, input logic ci,
                          input bit push, input logic [3:0] es, input logic ec, input logic eo,
                          input logic ez);
        exp_t e;
        start4 = 1'b1; mode4 = m; a4 = a; b4 = b; cin4 = ci;
        @(posedge Clk);
        #1;
        start4 = 1'b0;
        chk("busy4_after_start", {31'd0, busy4}, 32'd1);
        chk("done4_after_start", {31'd0, done4}, 32'd0);
        if (push) begin
            e.sum = {4'd0, es}; e.carry = ec; e.ovf = eo; e.zero = ez; e.cyc = cyc + 4;
            q4.push_back(e);
        end
    endtask

    task automatic issue8(input logic m, input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic ec, input logic eo, input logic ez);
        exp_t e;
        start8 = 1'b1; mode8 = m; a8 = a; b8 = b; cin8 = ci;
        @(posedge Clk);
        #1;
        start8 = 1'b0;
        e.sum = es; e.carry = ec; e.ovf = eo; e.zero = ez; e.cyc = cyc + 8;
        q8.push_back(e);
    endtask

    task automatic wait_done(input bit wide);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clk);
            seen = wide ? (done8 === 1'b1) : (done4 === 1'b1);
        end
        if (!seen) begin
            total++;
            $display("FAIL wait_done: no Done within 20 cycles (width %0d)", wide ? 8 : 4);
        end
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("reset_out4", {24'd0, busy4, done4, sum4, carry4, ovf4, zero4}, 32'd0);
        chk("reset_out8", {20'd0, busy8, done8, sum8, carry8, ovf8, zero8}, 32'd0);

        @(negedge Clk);
        issue4(1'b0, 4'd7, 4'd9, 1'b0, 1, 4'b0000, 1'b1, 1'b0, 1'b1);
        wait_done(0);
        @(negedge Clk);
        issue4(1'b0, 4'd5, 4'd3, 1'b1, 1, 4'b1001, 1'b0, 1'b1, 1'b0);
        wait_done(0);
        // Start held in the Done cycle: back-to-back subtractions.
        issue4(1'b1, 4'd3, 4'd5, 1'b1, 1, 4'b1110, 1'b0, 1'b0, 1'b0);
        wait_done(0);
        issue4(1'b1, 4'd8, 4'd1, 1'b0, 1, 4'b0111, 1'b1, 1'b1, 1'b0);
        wait_done(0);

        // A second Start two cycles into RUN must not disturb the first operation.
        @(negedge Clk);
        issue4(1'b0, 4'd2, 4'd3, 1'b0, 1, 4'b0101, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        start4 = 1'b1; mode4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        @(posedge Clk);
        #1;
        start4 = 1'b0;
        chk("busy4_ignored_start", {31'd0, busy4}, 32'd1);
        wait_done(0);
        repeat (2) @(negedge Clk);
        chk("sum4_held", {28'd0, sum4}, 32'd5);
        chk("idle4_after_done", {30'd0, busy4, done4}, 32'd0);

        // Reset in mid-RUN clears everything and suppresses Done.
        @(negedge Clk);
        issue4(1'b0, 4'd6, 4'd6, 1'b1, 0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("midrun_reset_out4", {24'd0, busy4, done4, sum4, carry4, ovf4, zero4}, 32'd0);
        repeat (8) @(negedge Clk);
        chk("no_done_after_reset", {31'd0, done4}, 32'd0);
        issue4(1'b0, 4'd1, 4'd1, 1'b0, 1, 4'b0010, 1'b0, 1'b0, 1'b0);
        wait_done(0);

        @(negedge Clk);
        issue8(1'b0, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0, 1'b0);
        wait_done(1);

        repeat (3) @(negedge Clk);
        chk("pending_results", q4.size() + q8.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
